rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Upstream transaction sequencer for the multiplexed address/data RTC bus-timing generator.
- Takes a host request (single or burst, read or write) and drives the timing generator's En_Esc/En_Lect enables.
- Consumes the generator's DIR1/DAT1/cambio_est/En_tristate flags.
- Drives the shared 8-bit AD bus in the address and write-data windows, and captures read data.

Parameters:
- GAP_CYCLES, 3: cycles both enables stay low between transactions so the generator's counter returns to 0 (minimum 2).
- TIMEOUT, 100: max cycles in RUN without cambio_est (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request pulse; sampled only in IDLE
- wr_nrd  in  1  1 = write, 0 = read
- addr  in  8  first RTC register address
- len  in  4  number of transactions; 0 treated as 1
- wdata  in  8  write data, sampled at entry to each RUN
- DIR1  in  1  address-window flag from timing generator
- DAT1  in  1  data-window flag from timing generator
- cambio_est  in  1  end-of-transaction flag from timing generator
- En_tristate  in  1  bus-drive window from timing generator
- bus_in  in  8  AD bus read-back
- En_Esc  out  1  write enable to timing generator
- En_Lect  out  1  read enable to timing generator
- bus_out  out  8  value driven on AD bus
- bus_oe  out  1  AD bus output enable
- rdata  out  8  captured read byte
- rdata_valid  out  1  1-cycle pulse per captured byte
- rdata_idx  out  4  transaction index of rdata (0-based)
- busy  out  1  high from start acceptance until done
- done  out  1  1-cycle pulse at burst completion
- error  out  1  sticky timeout flag (0 when feature absent)

Behaviour:
- Reset values: all outputs 0; bus_out = 0x00; state = IDLE. Reset mid-burst aborts immediately with no done pulse.
- States: IDLE, RUN, WAIT_END, GAP, DONE.
- IDLE:
  - On start = 1, latch wr_nrd, addr (into cur_addr), len (0 maps to 1) into remaining, idx = 0.
  - busy = 1 next cycle; go to RUN.
  - start while busy = 1 is ignored.
- RUN:
  - En_Esc = wr, En_Lect = !wr, both registered; exactly one is high.
  - wdata is latched on the RUN entry cycle.
  - Go to WAIT_END.
- WAIT_END:
  - Enable stays high.
  - bus_out = cur_addr while DIR1 = 1; bus_out = wdata latch while DAT1 = 1 and wr; otherwise bus_out holds.
  - bus_oe = En_tristate AND (DIR1 OR wr). The sequencer never drives the bus in the read data window.
  - Read capture: on the DAT1 1→0 edge with !wr, register rdata = bus_in, pulse rdata_valid for 1 cycle, present the current idx.
  - On the cambio_est 0→1 edge, drop the enable the next cycle and go to GAP.
- GAP:
  - Enables low, bus_oe = 0, for GAP_CYCLES cycles.
  - Then decrement remaining. If remaining > 0: cur_addr += 1 (8-bit wrap, 0xFF→0x00), idx += 1, go to RUN. Otherwise go to DONE.
- DONE: pulse done for 1 cycle, busy = 0 in the same cycle, go to IDLE.
- Simultaneous cambio_est and a DAT1 falling edge: capture first, then end the transaction. Both take effect the same cycle.
- Latency from start to first enable high: 2 cycles.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_END. At TIMEOUT cycles without cambio_est: set error (sticky until reset), drop enables, bus_oe = 0, go to DONE (done still pulses).
  - error clears only on reset.
- Undefined: no counter; error tied to 0; WAIT_END waits indefinitely.

Test Plan:
- Single write: start, wr_nrd = 1, addr = 0x21, wdata = 0x45, len = 1.
  - En_Esc high 2 cycles after start.
  - bus_out = 0x21 with bus_oe during the DIR1 window, then 0x45 during the DAT1 window.
  - done pulses once; En_Lect never high.
- Single read: wr_nrd = 0, addr = 0x23, bus model returns 0x59 in the data window.
  - rdata = 0x59, rdata_valid 1 cycle, rdata_idx = 0.
  - bus_oe = 0 throughout the DAT1 window.
- Burst read: addr = 0x21, len = 6.
  - Six rdata_valid pulses, idx 0..5, addresses 0x21..0x26 on the bus.
  - Enables low ≥ GAP_CYCLES between transactions; one done.
- Wrap and len = 0: addr = 0xFF, len = 2 gives addresses 0xFF then 0x00. A separate len = 0 request runs exactly one transaction.
- Reset and start while busy:
  - start during busy is ignored (no extra transaction).
  - reset asserted mid-WAIT_END: all outputs 0 immediately, no done pulse; a fresh start afterwards works.
- SEQ_TIMEOUT_EN, TIMEOUT = 100: hold cambio_est low.
  - error = 1 at cycle 100 of WAIT_END; done pulses; enables drop.
  - error stays 1 until reset.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: host request sequencer for the RTC bus-timing generator (optional WAIT_END timeout via SEQ_TIMEOUT_EN)
module rtc_bus_sequencer #(
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_nrd,
  input  logic [7:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wdata,
  input  logic       DIR1,
  input  logic       DAT1,
  input  logic       cambio_est,
  input  logic       En_tristate,
  input  logic [7:0] bus_in,
  output logic       En_Esc,
  output logic       En_Lect,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic [3:0] rdata_idx,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [2:0] {IDLE, RUN, WAIT_END, GAP, DONE} state_t;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  state_t state, next_state;
  logic          wr_q;
  logic [7:0]    cur_addr;
  logic [7:0]    wdata_q;
  logic [7:0]    bus_hold;
  logic [3:0]    remaining;
  logic [3:0]    idx;
  logic [GW-1:0] gap_cnt;
  logic          dat1_q;
  logic          cambio_q;
  logic          timeout_hit;
  logic          cambio_rise;
  logic          dat1_fall;
  assign cambio_rise = cambio_est & ~cambio_q;
  assign dat1_fall   = ~DAT1 & dat1_q;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;
  assign timeout_hit = (state == WAIT_END) && !cambio_rise && (to_cnt == TO_LAST);
  assign error = err_q;
  // cycles spent in WAIT_END, and the sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_END) ? to_cnt + 1'b1 : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = (TIMEOUT < 0);
  assign error = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end
  // next-state decode
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:     next_state = start ? RUN : IDLE;
      RUN:      next_state = WAIT_END;
      WAIT_END: next_state = cambio_rise ? GAP : timeout_hit ? DONE : WAIT_END;
      GAP:      next_state = (gap_cnt != GAP_LAST) ? GAP : (remaining > 4'd1) ? RUN : DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end
  // state-derived outputs; bus_out is transparent in its windows and holds otherwise
  always_comb begin
    busy    = (state == RUN) || (state == WAIT_END) || (state == GAP);
    done    = (state == DONE);
    bus_oe  = (state == WAIT_END) && En_tristate && (DIR1 || wr_q);
    bus_out = ((state == WAIT_END) && DIR1) ? cur_addr :
              ((state == WAIT_END) && DAT1 && wr_q) ? wdata_q : bus_hold;
  end
  // request latches, enables, burst bookkeeping and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q        <= 1'b0;
      cur_addr    <= 8'h00;
      wdata_q     <= 8'h00;
      bus_hold    <= 8'h00;
      remaining   <= 4'd0;
      idx         <= 4'd0;
      gap_cnt     <= '0;
      dat1_q      <= 1'b0;
      cambio_q    <= 1'b0;
      En_Esc      <= 1'b0;
      En_Lect     <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      rdata_idx   <= 4'd0;
    end else begin
      dat1_q      <= DAT1;
      cambio_q    <= cambio_est;
      bus_hold    <= bus_out;
      En_Esc      <= (next_state == WAIT_END) && wr_q;
      En_Lect     <= (next_state == WAIT_END) && !wr_q;
      rdata_valid <= 1'b0;
      gap_cnt     <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        wr_q      <= wr_nrd;
        cur_addr  <= addr;
        remaining <= (len == 4'd0) ? 4'd1 : len;
        idx       <= 4'd0;
      end
      if (state == RUN) wdata_q <= wdata;
      if (state == WAIT_END && dat1_fall && !wr_q) begin
        rdata       <= bus_in;
        rdata_valid <= 1'b1;
        rdata_idx   <= idx;
      end
      if (state == GAP && gap_cnt == GAP_LAST) begin
        remaining <= remaining - 4'd1;
        if (remaining > 4'd1) begin
          cur_addr <= cur_addr + 8'd1;
          idx      <= idx + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: table-driven and randomized checks of rtc_bus_sequencer against an RTC memory model
module tb_rtc_bus_sequencer;
  localparam int GAP = 3;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, wr_nrd = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, bus_in = 8'h00;
  logic [3:0] len = 4'd0;
  logic DIR1 = 1'b0, DAT1 = 1'b0, cambio_est = 1'b0, En_tristate = 1'b0;
  logic En_Esc, En_Lect, bus_oe, rdata_valid, busy, done, error;
  logic [7:0] bus_out, rdata;
  logic [3:0] rdata_idx;

  rtc_bus_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_nrd(wr_nrd), .addr(addr), .len(len),
    .wdata(wdata), .DIR1(DIR1), .DAT1(DAT1), .cambio_est(cambio_est), .En_tristate(En_tristate),
    .bus_in(bus_in), .En_Esc(En_Esc), .En_Lect(En_Lect), .bus_out(bus_out), .bus_oe(bus_oe),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_idx(rdata_idx), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rtc_addr = 8'h00;
  bit hold_cambio = 1'b0;
  int gcnt = 0;

  int n_done, n_en_rise, esc_seen, lect_seen, both_en, oe_rd_dat, min_gap, low_run, en_hi;
  bit seen_fall, en_prev, dir_prev, dat_prev;
  logic [7:0] addr_q[$], wd_q[$], rd_d[$];
  logic [3:0] rd_i[$];

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] wdata;
    int         exp_n;
    logic [7:0] exp_last;
    int         exp_rd0;
    bit         extra;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  task automatic clear_mon();
    n_done = 0; n_en_rise = 0; esc_seen = 0; lect_seen = 0; both_en = 0;
    oe_rd_dat = 0; min_gap = 999; low_run = 0; en_hi = 0; seen_fall = 1'b0;
    addr_q.delete(); wd_q.delete(); rd_d.delete(); rd_i.delete();
  endtask

  // timing-generator model: counts while an enable is high and decodes the windows
  initial forever begin
    @(posedge clk);
    #1;
    gcnt = (En_Esc || En_Lect) ? gcnt + 1 : 0;
    DIR1 = (gcnt >= 1 && gcnt <= 3);
    DAT1 = (gcnt >= 5 && gcnt <= 8);
    En_tristate = DIR1 || DAT1;
    cambio_est = (gcnt == 10) && !hold_cambio;
    bus_in = (gcnt >= 5 && En_Lect) ? mem[rtc_addr] : 8'hEE;
  end

  // bus monitor and RTC register file
  initial forever begin
    @(negedge clk);
    if (En_Esc && En_Lect) both_en++;
    if (En_Esc) esc_seen++;
    if (En_Lect) lect_seen++;
    if (En_Esc || En_Lect) en_hi++;
    if ((En_Esc || En_Lect) && !en_prev) begin
      n_en_rise++;
      if (seen_fall && low_run < min_gap) min_gap = low_run;
    end
    if (!(En_Esc || En_Lect) && en_prev) begin seen_fall = 1'b1; low_run = 1; end
    else if (!(En_Esc || En_Lect)) low_run++;
    if (bus_oe && DIR1 && !dir_prev) addr_q.push_back(bus_out);
    if (bus_oe && DAT1 && !dat_prev) wd_q.push_back(bus_out);
    if (bus_oe && DIR1) rtc_addr = bus_out;
    if (bus_oe && DAT1) mem[rtc_addr] = bus_out;
    if (DAT1 && bus_oe && En_Lect) oe_rd_dat++;
    if (rdata_valid) begin rd_d.push_back(rdata); rd_i.push_back(rdata_idx); end
    if (done) n_done++;
    en_prev = En_Esc || En_Lect;
    dir_prev = bus_oe && DIR1;
    dat_prev = bus_oe && DAT1;
  end

  task automatic run_req(input logic wr, input logic [7:0] a, input logic [3:0] l,
                         input logic [7:0] wd, input bit extra);
    int n, cyc, t;
    bit pulsed;
    logic [7:0] ea;
    n = (l == 4'd0) ? 1 : int'(l);
    clear_mon();
    wr_nrd = wr; addr = a; len = l; wdata = wd;
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) chk("busy_after_start", busy, 1);
    end while (!(En_Esc || En_Lect) && cyc < 10);
    chk("start_to_enable", cyc, 2);
    t = 0;
    pulsed = 1'b0;
    while (n_done == 0 && t < 40 * (n + 1) + 200) begin
      @(negedge clk);
      t++;
      if (start) start = 1'b0;
      else if (extra && !pulsed && busy) begin start = 1'b1; addr = a ^ 8'h80; pulsed = 1'b1; end
    end
    start = 1'b0;
    chk("done_seen", int'(n_done > 0), 1);
    repeat (3) @(negedge clk);
    chk("done_once", n_done, 1);
    chk("busy_clear", busy, 0);
    chk("txn_count", n_en_rise, n);
    chk("addr_count", addr_q.size(), n);
    for (int i = 0; i < addr_q.size(); i++) begin
      ea = 8'(a + i);
      chk("addr", addr_q[i], ea);
    end
    if (wr) begin
      chk("lect_in_write", lect_seen, 0);
      chk("wdata_count", wd_q.size(), n);
      for (int i = 0; i < wd_q.size(); i++) chk("wdata_on_bus", wd_q[i], wd);
      chk("rdata_in_write", rd_d.size(), 0);
      for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wd;
    end else begin
      chk("esc_in_read", esc_seen, 0);
      chk("oe_in_read_data", oe_rd_dat, 0);
      chk("rd_count", rd_d.size(), n);
      for (int i = 0; i < rd_d.size(); i++) begin
        ea = 8'(a + i);
        chk("rd_idx", rd_i[i], i);
        chk("rd_data", rd_d[i], ref_mem[ea]);
      end
    end
    chk("both_enables", both_en, 0);
    chk("min_gap_ok", int'(min_gap >= GAP), 1);
    chk("error_low", error, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 8'h21, 4'd1, 8'h45, 1, 8'h21, -1, 1'b0};
    tbl[1] = '{1'b0, 8'h23, 4'd1, 8'h00, 1, 8'h23, 'h59, 1'b0};
    tbl[2] = '{1'b0, 8'h21, 4'd6, 8'h00, 6, 8'h26, 'h45, 1'b1};
    tbl[3] = '{1'b0, 8'hFF, 4'd2, 8'h00, 2, 8'h00, -1, 1'b0};
    tbl[4] = '{1'b0, 8'h40, 4'd0, 8'h00, 1, 8'h40, -1, 1'b0};
    tbl[5] = '{1'b1, 8'h30, 4'd3, 8'hA5, 3, 8'h32, -1, 1'b1};
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[8'h23] = 8'h59;
    ref_mem[8'h23] = 8'h59;
    clear_mon();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {En_Esc, En_Lect, bus_out, bus_oe, rdata, rdata_valid, rdata_idx, busy, done, error}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      run_req(tbl[v].wr, tbl[v].addr, tbl[v].len, tbl[v].wdata, tbl[v].extra);
      chk("tbl_txn_count", n_en_rise, tbl[v].exp_n);
      chk("tbl_last_addr", addr_q.size() > 0 ? int'(addr_q[addr_q.size() - 1]) : -1, tbl[v].exp_last);
      if (tbl[v].exp_rd0 >= 0) chk("tbl_first_rdata", rd_d.size() > 0 ? int'(rd_d[0]) : -1, tbl[v].exp_rd0);
    end

    begin : reset_mid_burst
      int t;
      clear_mon();
      wr_nrd = 1'b0; addr = 8'h50; len = 4'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (n_en_rise < 2 && t < 300) begin @(negedge clk); t++; end
      chk("reach_second_txn", int'(n_en_rise >= 2), 1);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("reset_mid_outputs", {En_Esc, En_Lect, bus_out, bus_oe, rdata, rdata_valid, rdata_idx, busy, done, error}, 0);
      repeat (5) @(negedge clk);
      chk("reset_no_done", n_done, 0);
      reset = 1'b1;
      @(negedge clk);
      run_req(1'b0, 8'h50, 4'd2, 8'h00, 1'b0);
    end

    for (int r = 0; r < 12; r++)
      run_req(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 6)),
              8'($urandom), ($urandom_range(0, 3) == 0));

`ifdef SEQ_TIMEOUT_EN
    begin : timeout_case
      int t;
      hold_cambio = 1'b1;
      clear_mon();
      wr_nrd = 1'b0; addr = 8'h10; len = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (n_done == 0 && t < 400) begin @(negedge clk); t++; end
      chk("timeout_done", n_done, 1);
      chk("timeout_enable_cycles", en_hi, TO);
      chk("timeout_error_set", error, 1);
      chk("timeout_enables_low", {En_Esc, En_Lect, bus_oe}, 0);
      hold_cambio = 1'b0;
      repeat (20) @(negedge clk);
      chk("timeout_error_sticky", error, 1);
      reset = 1'b0;
      #1;
      chk("timeout_error_cleared", error, 0);
      @(negedge clk);
      reset = 1'b1;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
